ula_controle: RTL and testbench
===============================

ULA_CONTROLE -- requirements
Module: ula_controle

Interface
REQ-001 Parameter REG_RST, default 8'h00: reset value of registers r1..r3.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  in  1  instruction offered.
REQ-005 in_ready  out  1  block can accept an instruction.
REQ-006 instr  in  16  op[15:13], rd[12:11], rs1[10:9], is_imm[8], imm[7:0] (rs2 = instr[1:0] when is_imm=0).
REQ-007 SrcA  out  8  ALU operand A.
REQ-008 SrcB  out  8  ALU operand B.
REQ-009 ULAControl  out  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 SLT, 110 DIV, 111 XOR.
REQ-010 ULAResult  in  8  combinational ALU result for the current SrcA/SrcB/ULAControl.
REQ-011 FlagZ  in  1  ALU zero flag.
REQ-012 out_valid  out  1  response available.
REQ-013 out_ready  in  1  consumer takes response.
REQ-014 result  out  8  captured result.
REQ-015 zero  out  1  captured zero flag.
REQ-016 div_zero  out  1  response is a divide-by-zero error.

Function
REQ-017 Register file: four 8-bit registers r0..r3; r0 reads 0 and ignores writes.
REQ-018 FSM states: IDLE, OPER, RESP.
REQ-019 IDLE: in_ready=1; on in_valid&in_ready, latch instr and go to OPER; otherwise stay.
REQ-020 OPER: in_ready=0; SrcA=r[rs1]; SrcB=imm when is_imm=1, else r[rs2]; ULAControl=op.
REQ-021 OPER: unconditionally go to RESP on the next edge.
REQ-022 OPER edge: capture ULAResult into result and FlagZ into zero; write ULAResult to r[rd].
REQ-023 Divide-by-zero (op=110 and SrcB=0) at OPER edge: result=8'hFF, zero=0, div_zero=1, no register write; FlagZ and ULAResult ignored.
REQ-024 RESP: out_valid=1; result, zero and div_zero stable; go to IDLE on out_ready.
REQ-025 RESP: hold all outputs unchanged while out_ready=0, for any number of cycles.
REQ-026 Latency: accept on edge E0, out_valid high after edge E1; one instruction in flight at most.
REQ-027 Throughput: out_ready=1 in RESP gives one instruction per 3 cycles (in_ready high in the cycle after the RESP exit edge).
REQ-028 Outside OPER: SrcA=0, SrcB=0, ULAControl=000.
REQ-029 Reads in OPER see the writes of all earlier instructions (write completes at the OPER edge, before the next accept).
REQ-030 SLT and all operands are unsigned 8-bit; MUL keeps low 8 bits (ALU behaviour, passed through).
REQ-031 out_valid=0 in IDLE and OPER; in_valid is ignored outside IDLE.

Reset
REQ-032 rst_n low: state=IDLE, r1..r3=REG_RST, result=0, zero=0, div_zero=0, out_valid=0, in_ready=0 while asserted.
REQ-033 Reset asserted in OPER or RESP: abort; no register write, pending response discarded.
REQ-034 First accept is possible on the first rising edge after rst_n deasserts.

Structure
REQ-035 Shared package ula_pkg: 3-bit op enum (8 codes above), FSM state enum, instr field position constants.
REQ-036 One sub-module ula_regfile (4x8, one write port, two combinational read ports, r0 hardwired zero); FSM and capture logic stay in ula_controle.
REQ-037 ALU itself is external; SrcA/SrcB/ULAControl connect to it directly, with no registering inside this block.

Verification
REQ-038 After reset: ADD r1,r0,#5 -> result=8'h05, zero=0; then reading r1 via ADD r2,r1,#0 -> result=8'h05.
REQ-039 r1=5: SUB r3,r1,#5 -> result=8'h00, zero=1, r3=0.
REQ-040 r1=5: DIV r2,r1,#0 -> div_zero=1, result=8'hFF, r2 unchanged; next DIV r2,r1,#2 -> result=8'h02, div_zero=0.
REQ-041 out_ready held low 4 cycles in RESP -> out_valid, result, zero held; in_ready=0 throughout; release -> IDLE next edge.
REQ-042 Write to r0 (ADD r0,r0,#7), then ADD r1,r0,#0 -> result=8'h00, zero=1.
REQ-043 rst_n pulsed low during OPER of ADD r1,r0,#9 -> no response, r1=REG_RST, in_ready=1 after release.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the ALU controller: opcode and FSM encodings,
// plus bit positions of the fields inside a 16-bit instruction word.
package ula_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_MUL = 3'b100,
        OP_SLT = 3'b101,
        OP_DIV = 3'b110,
        OP_XOR = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPER = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int INSTR_W  = 16;
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 13;
    localparam int RD_MSB   = 12;
    localparam int RD_LSB   = 11;
    localparam int RS1_MSB  = 10;
    localparam int RS1_LSB  = 9;
    localparam int IMM_FLAG = 8;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;
    localparam int RS2_MSB  = 1;
    localparam int RS2_LSB  = 0;

endpackage

// File: rtl/ula_regfile.sv
// Four 8-bit registers, r0 hardwired to zero; one write port and two
// combinational read ports so operands are visible in the same cycle.
module ula_regfile #(
    parameter logic [7:0] REG_RST = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [7:0] wdata,
    input  logic [1:0] raddr_a,
    output logic [7:0] rdata_a,
    input  logic [1:0] raddr_b,
    output logic [7:0] rdata_b
);

    logic [7:0] rf_q [4];

    assign rf_q[0] = 8'h00;

    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_reg
            logic [7:0] q_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= REG_RST;
                end else if (we && (waddr == 2'(gi))) begin
                    q_reg <= wdata;
                end
            end

            assign rf_q[gi] = q_reg;
        end
    endgenerate

    assign rdata_a = rf_q[raddr_a];
    assign rdata_b = rf_q[raddr_b];

endmodule

// File: rtl/ula_controle.sv
// Sequencer for an external combinational ALU: accepts one instruction,
// drives the ALU for one cycle, captures its result and holds the response.
module ula_controle
    import ula_pkg::*;
#(
    parameter logic [7:0] REG_RST = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] instr,
    output logic [7:0]  SrcA,
    output logic [7:0]  SrcB,
    output logic [2:0]  ULAControl,
    input  logic [7:0]  ULAResult,
    input  logic        FlagZ,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  result,
    output logic        zero,
    output logic        div_zero
);

    state_e               state_reg;
    state_e               state_next;
    logic [INSTR_W-1:0]   instr_reg;
    logic [7:0]           result_reg;
    logic                 zero_reg;
    logic                 div_zero_reg;

    logic                 accept;
    logic                 oper;
    logic [2:0]           op_field;
    logic [7:0]           rdata_a;
    logic [7:0]           rdata_b;
    logic [7:0]           operand_b;
    logic                 div_by_zero;
    logic                 rf_we;

    assign oper      = (state_reg == ST_OPER);
    assign in_ready  = rst_n && (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_RESP);
    assign accept    = in_valid && in_ready;
    assign op_field  = instr_reg[OP_MSB:OP_LSB];

    ula_regfile #(
        .REG_RST (REG_RST)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (instr_reg[RD_MSB:RD_LSB]),
        .wdata   (ULAResult),
        .raddr_a (instr_reg[RS1_MSB:RS1_LSB]),
        .rdata_a (rdata_a),
        .raddr_b (instr_reg[RS2_MSB:RS2_LSB]),
        .rdata_b (rdata_b)
    );

    assign operand_b = instr_reg[IMM_FLAG] ? instr_reg[IMM_MSB:IMM_LSB] : rdata_b;

    // A zero divisor is detected here, not from the ALU, so the error
    // response does not depend on what the ALU does with it.
    assign div_by_zero = oper && (op_field == OP_DIV) && (operand_b == 8'h00);
    assign rf_we       = oper && !div_by_zero;

    // ALU operands are parked at zero outside the execute cycle.
    always_comb begin
        SrcA       = 8'h00;
        SrcB       = 8'h00;
        ULAControl = OP_ADD;
        if (oper) begin
            SrcA       = rdata_a;
            SrcB       = operand_b;
            ULAControl = op_field;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_OPER;
            ST_OPER: state_next = ST_RESP;
            ST_RESP: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_reg    <= '0;
            result_reg   <= 8'h00;
            zero_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            if (accept) begin
                instr_reg <= instr;
            end
            if (oper) begin
                if (div_by_zero) begin
                    result_reg   <= 8'hFF;
                    zero_reg     <= 1'b0;
                    div_zero_reg <= 1'b1;
                end else begin
                    result_reg   <= ULAResult;
                    zero_reg     <= FlagZ;
                    div_zero_reg <= 1'b0;
                end
            end
        end
    end

    assign result   = result_reg;
    assign zero     = zero_reg;
    assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_ula_controle.sv
// Self-checking bench for ula_controle with a behavioural ALU stand-in and
// an architectural register model.
module tb_ula_controle;

    localparam logic [7:0] RST_VAL = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [7:0]  SrcA;
    logic [7:0]  SrcB;
    logic [2:0]  ULAControl;
    logic [7:0]  ULAResult;
    logic        FlagZ;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  result;
    logic        zero;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    logic [7:0] mreg [4];

    ula_controle #(
        .REG_RST (RST_VAL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ULAControl (ULAControl),
        .ULAResult  (ULAResult),
        .FlagZ      (FlagZ),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return p[7:0];
            3'd5:    return (a < b) ? 8'd1 : 8'd0;
            3'd6:    return (b == 8'd0) ? 8'd0 : a / b;
            default: return a ^ b;
        endcase
    endfunction

    // External ALU; on divide by zero it reports 0 with FlagZ=1, which the DUT must ignore.
    assign ULAResult = alu_ref(ULAControl, SrcA, SrcB);
    assign FlagZ     = (ULAResult == 8'h00);

    function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [7:0] imm);
        return {op, rd, rs1, 1'b1, imm};
    endfunction

    function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, 1'b0, 6'd0, rs2};
    endfunction

    task automatic model_reset();
        mreg[0] = 8'h00;
        for (int i = 1; i < 4; i++) mreg[i] = RST_VAL;
    endtask

    task automatic model_exec(input logic [15:0] ins, output logic [7:0] ea, output logic [7:0] eb,
                              output logic [7:0] er, output logic ez, output logic edz);
        logic [2:0] op;
        logic [1:0] rd;
        op = ins[15:13];
        rd = ins[12:11];
        ea = mreg[ins[10:9]];
        eb = ins[8] ? ins[7:0] : mreg[ins[1:0]];
        if (op == 3'd6 && eb == 8'd0) begin
            er  = 8'hFF;
            ez  = 1'b0;
            edz = 1'b1;
        end else begin
            er  = alu_ref(op, ea, eb);
            ez  = (er == 8'h00);
            edz = 1'b0;
            if (rd != 2'd0) mreg[rd] = er;
        end
    endtask

    // Called at a negedge in IDLE; returns at a negedge back in IDLE.
    task automatic issue(input logic [15:0] ins, input int hold,
                         output logic rdy, output logic [7:0] sa, output logic [7:0] sb, output logic [2:0] ctl,
                         output logic ov, output logic [7:0] res, output logic z, output logic dz);
        rdy      = in_ready;
        in_valid = 1'b1;
        instr    = ins;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        instr    = 16'($urandom);
        @(negedge clk);
        sa  = SrcA;
        sb  = SrcB;
        ctl = ULAControl;
        @(negedge clk);
        ov  = out_valid;
        res = result;
        z   = zero;
        dz  = div_zero;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
        end
        checks++;
        if (result !== 8'h00 || zero !== 1'b0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_capture: result=%h zero=%b div_zero=%b required 00 0 0", result, zero, div_zero);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || SrcA !== 8'h00 || SrcB !== 8'h00 || ULAControl !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b SrcA=%h SrcB=%h ctl=%0d required 1 00 00 0",
                     in_ready, SrcA, SrcB, ULAControl);
        end
        $display("test_reset: in_ready=%b after release", in_ready);
    endtask

    // Table-driven directed sequence; starts right after reset so the first
    // accept lands on the first edge after release.
    task automatic test_directed();
        logic [15:0] tab_ins [9];
        logic [7:0]  tab_res [9];
        logic        tab_z   [9];
        logic        tab_dz  [9];
        logic rdy, ov, z, dz, ez, edz;
        logic [7:0] sa, sb, res, ea, eb, er;
        logic [2:0] ctl;
        tab_ins[0] = enc_i(3'd0, 2'd1, 2'd0, 8'd5); tab_res[0] = 8'h05; tab_z[0] = 1'b0; tab_dz[0] = 1'b0;
        tab_ins[1] = enc_i(3'd0, 2'd2, 2'd1, 8'd0); tab_res[1] = 8'h05; tab_z[1] = 1'b0; tab_dz[1] = 1'b0;
        tab_ins[2] = enc_i(3'd1, 2'd3, 2'd1, 8'd5); tab_res[2] = 8'h00; tab_z[2] = 1'b1; tab_dz[2] = 1'b0;
        tab_ins[3] = enc_i(3'd0, 2'd0, 2'd3, 8'd0); tab_res[3] = 8'h00; tab_z[3] = 1'b1; tab_dz[3] = 1'b0;
        tab_ins[4] = enc_i(3'd6, 2'd2, 2'd1, 8'd0); tab_res[4] = 8'hFF; tab_z[4] = 1'b0; tab_dz[4] = 1'b1;
        tab_ins[5] = enc_i(3'd0, 2'd0, 2'd2, 8'd0); tab_res[5] = 8'h05; tab_z[5] = 1'b0; tab_dz[5] = 1'b0;
        tab_ins[6] = enc_i(3'd6, 2'd2, 2'd1, 8'd2); tab_res[6] = 8'h02; tab_z[6] = 1'b0; tab_dz[6] = 1'b0;
        tab_ins[7] = enc_i(3'd0, 2'd0, 2'd0, 8'd7); tab_res[7] = 8'h07; tab_z[7] = 1'b0; tab_dz[7] = 1'b0;
        tab_ins[8] = enc_i(3'd0, 2'd1, 2'd0, 8'd0); tab_res[8] = 8'h00; tab_z[8] = 1'b1; tab_dz[8] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            model_exec(tab_ins[i], ea, eb, er, ez, edz);
            issue(tab_ins[i], 0, rdy, sa, sb, ctl, ov, res, z, dz);
            checks++;
            if (rdy !== 1'b1 || ov !== 1'b1) begin
                errors++;
                $display("FAIL directed_hs[%0d]: in_ready=%b out_valid=%b required 1 1", i, rdy, ov);
            end
            checks++;
            if (res !== tab_res[i] || z !== tab_z[i] || dz !== tab_dz[i]) begin
                errors++;
                $display("FAIL directed_resp[%0d]: result=%h zero=%b div_zero=%b required %h %b %b",
                         i, res, z, dz, tab_res[i], tab_z[i], tab_dz[i]);
            end
            $display("directed[%0d]: instr=%h result=%h zero=%b div_zero=%b", i, tab_ins[i], res, z, dz);
        end
    endtask

    task automatic test_hold();
        logic [15:0] ins;
        logic [7:0] ea, eb, er, r0;
        logic ez, edz, z0, d0;
        ins = enc_r(3'd7, 2'd3, 2'd2, 2'd1);
        model_exec(ins, ea, eb, er, ez, edz);
        in_valid = 1'b1;
        instr    = ins;
        @(posedge clk);
        #1;
        instr = enc_i(3'd0, 2'd1, 2'd0, 8'h33);
        @(negedge clk);
        @(negedge clk);
        r0 = result;
        z0 = zero;
        d0 = div_zero;
        checks++;
        if (r0 !== er || z0 !== ez || d0 !== edz) begin
            errors++;
            $display("FAIL hold_first: result=%h zero=%b div_zero=%b required %h %b %b", r0, z0, d0, er, ez, edz);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== r0 || zero !== z0 || div_zero !== d0) begin
                errors++;
                $display("FAIL hold_cycle[%0d]: out_valid=%b in_ready=%b result=%h zero=%b div_zero=%b required 1 0 %h %b %b",
                         c, out_valid, in_ready, result, zero, div_zero, r0, z0, d0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        $display("test_hold: result=%h held 4 cycles", r0);
    endtask

    task automatic test_random();
        logic [15:0] ins;
        logic rdy, ov, z, dz, ez, edz;
        logic [7:0] sa, sb, res, ea, eb, er;
        logic [2:0] ctl;
        for (int i = 0; i < 60; i++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ins[7:0] = 8'h00;
            if ($urandom_range(0, 4) == 0) ins[15:13] = 3'd6;
            model_exec(ins, ea, eb, er, ez, edz);
            issue(ins, int'($urandom_range(0, 3)), rdy, sa, sb, ctl, ov, res, z, dz);
            checks++;
            if (sa !== ea || sb !== eb || ctl !== ins[15:13]) begin
                errors++;
                $display("FAIL rand_alu_in[%0d]: SrcA=%h SrcB=%h ctl=%0d required %h %h %0d",
                         i, sa, sb, ctl, ea, eb, ins[15:13]);
            end
            checks++;
            if (rdy !== 1'b1 || ov !== 1'b1 || res !== er || z !== ez || dz !== edz) begin
                errors++;
                $display("FAIL rand_resp[%0d]: rdy=%b ov=%b result=%h zero=%b div_zero=%b required 1 1 %h %b %b",
                         i, rdy, ov, res, z, dz, er, ez, edz);
            end
            $display("random[%0d]: instr=%h A=%h B=%h result=%h zero=%b div_zero=%b", i, ins, sa, sb, res, z, dz);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ins;
        logic [7:0] ea, eb, er;
        logic ez, edz;
        int acc;
        int resp;
        acc  = 0;
        resp = 0;
        ins  = enc_i(3'd0, 2'd1, 2'd1, 8'd1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        instr     = ins;
        for (int i = 0; i < 12; i++) begin
            if (in_ready === 1'b1) acc++;
            if (out_valid === 1'b1) begin
                resp++;
                model_exec(ins, ea, eb, er, ez, edz);
                checks++;
                if (result !== er || zero !== ez) begin
                    errors++;
                    $display("FAIL b2b_resp[%0d]: result=%h zero=%b required %h %b", resp, result, zero, er, ez);
                end
                $display("back_to_back: response %0d result=%h", resp, result);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (acc != 4 || resp != 4) begin
            errors++;
            $display("FAIL b2b_rate: accepts=%0d responses=%0d required 4 4 in 12 cycles", acc, resp);
        end
    endtask

    task automatic test_reset_abort();
        logic rdy, ov, z, dz;
        logic [7:0] sa, sb, res;
        logic [2:0] ctl;
        int seen;
        in_valid = 1'b1;
        instr    = enc_i(3'd0, 2'd1, 2'd0, 8'd9);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (SrcB !== 8'd9) begin
            errors++;
            $display("FAIL abort_oper: SrcB=%h required 09", SrcB);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || SrcB !== 8'h00) begin
            errors++;
            $display("FAIL abort_in_reset: in_ready=%b out_valid=%b SrcB=%h required 0 0 00", in_ready, out_valid, SrcB);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1 || result !== 8'h00) begin
            errors++;
            $display("FAIL abort_release: in_ready=%b result=%h required 1 00", in_ready, result);
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_resp: out_valid seen %0d cycles required 0", seen);
        end
        issue(enc_i(3'd0, 2'd2, 2'd1, 8'd0), 0, rdy, sa, sb, ctl, ov, res, z, dz);
        mreg[2] = RST_VAL;
        checks++;
        if (res !== RST_VAL) begin
            errors++;
            $display("FAIL abort_r1: r1 read=%h required %h", res, RST_VAL);
        end
        $display("test_reset_abort: r1 after abort=%h", res);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
